// File: rtl/group_fifo_ctrl_if.sv
// Handshake bundle between the group FIFO sequencer (slave) and its SFTM/DPM/FIFO
// environment (master).
interface group_fifo_ctrl_if #(
    parameter int CW = 2
);
    logic          flush;
    logic          sftm_req;
    logic          sftm_grant;
    logic          sftm_wr;
    logic          fifo_wr_en;
    logic          fifo_group_done;
    logic          dpm_ready;
    logic          fifo_rd_en;
    logic          fifo_rd_valid;
    logic          fifo_error;
    logic          dpm_sog;
    logic          dpm_eog;
    logic [CW-1:0] groups_ready;
    logic [CW-1:0] credits;
    logic          err;

    modport slave (
        input  flush, sftm_req, sftm_wr, dpm_ready, fifo_rd_valid, fifo_error,
        output sftm_grant, fifo_wr_en, fifo_group_done, fifo_rd_en,
               dpm_sog, dpm_eog, groups_ready, credits, err
    );

    modport master (
        output flush, sftm_req, sftm_wr, dpm_ready, fifo_rd_valid, fifo_error,
        input  sftm_grant, fifo_wr_en, fifo_group_done, fifo_rd_en,
               dpm_sog, dpm_eog, groups_ready, credits, err
    );
endinterface

// File: rtl/group_fifo_ctrl.sv
// Group-level sequencer for the SFTM->DPM group FIFO: grants whole-group write
// bursts against free slots, issues one-group read bursts and tags start/end of group.
module group_fifo_ctrl #(
    parameter int GROUP_WORDS  = 4,
    parameter int DEPTH_GROUPS = 2,
    parameter int CW           = $clog2(DEPTH_GROUPS + 1),
    parameter int WW           = $clog2(GROUP_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    group_fifo_ctrl_if.slave bus
);
    typedef enum logic { W_IDLE, W_BURST } wstate_t;
    typedef enum logic { R_IDLE, R_BURST } rstate_t;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH_GROUPS);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [WW-1:0] LAST_W  = WW'(GROUP_WORDS - 1);
    localparam logic [WW-1:0] ONE_W   = WW'(1);

    wstate_t       wstate_q, wstate_d;
    rstate_t       rstate_q, rstate_d;
    logic [WW-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
    logic [CW-1:0] reserved_q, reserved_d, groups_ready_q, groups_ready_d;
    logic          sog_p_q, sog_p_d, eog_p_q, eog_p_d;
    logic          rd_pend_q, rd_pend_d, err_q, err_d;

    logic grant, wr_en, group_done, rd_en, rd_last, rd_start, cnt_fault;

    always_comb begin
        grant      = !bus.flush && (wstate_q == W_IDLE) && bus.sftm_req && (reserved_q < DEPTH_C);
        wr_en      = bus.sftm_wr && (wstate_q == W_BURST);
        group_done = wr_en && (wcnt_q == LAST_W);
        rd_en      = (rstate_q == R_BURST) && bus.dpm_ready;
        rd_last    = rd_en && (rcnt_q == LAST_W);
        rd_start   = (rstate_q == R_IDLE) && (groups_ready_q != '0);

        wstate_d       = wstate_q;
        rstate_d       = rstate_q;
        wcnt_d         = wcnt_q;
        rcnt_d         = rcnt_q;
        reserved_d     = reserved_q;
        groups_ready_d = groups_ready_q;

        if (grant) wstate_d = W_BURST;
        if (wr_en) begin
            if (wcnt_q == LAST_W) begin
                wcnt_d   = '0;
                wstate_d = W_IDLE;
            end else begin
                wcnt_d = wcnt_q + ONE_W;
            end
        end

        if (rd_start) rstate_d = R_BURST;
        if (rd_en) begin
            if (rcnt_q == LAST_W) begin
                rcnt_d   = '0;
                rstate_d = R_IDLE;
            end else begin
                rcnt_d = rcnt_q + ONE_W;
            end
        end

        // Simultaneous increment and decrement cancel out.
        case ({grant, rd_last})
            2'b10:   reserved_d = reserved_q + ONE_C;
            2'b01:   reserved_d = reserved_q - ONE_C;
            default: reserved_d = reserved_q;
        endcase
        case ({group_done, rd_start})
            2'b10:   groups_ready_d = groups_ready_q + ONE_C;
            2'b01:   groups_ready_d = groups_ready_q - ONE_C;
            default: groups_ready_d = groups_ready_q;
        endcase

        sog_p_d   = rd_en && (rcnt_q == '0);
        eog_p_d   = rd_last;
        rd_pend_d = rd_en;

        cnt_fault = (grant && !rd_last && (reserved_q == DEPTH_C)) ||
                    (rd_last && !grant && (reserved_q == '0)) ||
                    (group_done && !rd_start && (groups_ready_q == DEPTH_C));
        err_d = err_q || (bus.sftm_wr && (wstate_q == W_IDLE)) || bus.fifo_error ||
                (bus.fifo_rd_valid && !rd_pend_q) || cnt_fault;

        // Flush discards everything in flight but keeps the sticky error.
        if (bus.flush) begin
            wstate_d       = W_IDLE;
            rstate_d       = R_IDLE;
            wcnt_d         = '0;
            rcnt_d         = '0;
            reserved_d     = '0;
            groups_ready_d = '0;
            sog_p_d        = 1'b0;
            eog_p_d        = 1'b0;
            rd_pend_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate_q       <= W_IDLE;
            rstate_q       <= R_IDLE;
            wcnt_q         <= '0;
            rcnt_q         <= '0;
            reserved_q     <= '0;
            groups_ready_q <= '0;
            sog_p_q        <= 1'b0;
            eog_p_q        <= 1'b0;
            rd_pend_q      <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            wstate_q       <= wstate_d;
            rstate_q       <= rstate_d;
            wcnt_q         <= wcnt_d;
            rcnt_q         <= rcnt_d;
            reserved_q     <= reserved_d;
            groups_ready_q <= groups_ready_d;
            sog_p_q        <= sog_p_d;
            eog_p_q        <= eog_p_d;
            rd_pend_q      <= rd_pend_d;
            err_q          <= err_d;
        end
    end

    assign bus.sftm_grant      = grant;
    assign bus.fifo_wr_en      = wr_en;
    assign bus.fifo_group_done = group_done;
    assign bus.fifo_rd_en      = rd_en;
    assign bus.dpm_sog         = sog_p_q && bus.fifo_rd_valid;
    assign bus.dpm_eog         = eog_p_q && bus.fifo_rd_valid;
    assign bus.groups_ready    = groups_ready_q;
    assign bus.credits         = DEPTH_C - reserved_q;
    assign bus.err             = err_q;
endmodule
